// File: rtl/pipeline_pkg.sv
// Shared pipeline types: width defaults, MEM-stage FSM states, MEM/WB bundle.
// Also holds the word-alignment helper used when MEM_ALIGN_CHECK_EN is defined.
package pipeline_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 32;
  localparam int REG_AW_DEF = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                  valid;
    logic                  regwrite;
    logic [REG_AW_DEF-1:0] rd;
    logic [DATA_W_DEF-1:0] wbdata;
    logic                  exc;
  } memwb_t;

  function automatic logic misaligned(
    input logic [1:0] lo
  );
    return lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_stage_dmem_req_ctrl.sv
// Data-memory request FSM: request hold registers, writeback holding
// flops and upstream stall generation.
module dmem_req_ctrl
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              we_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              regwrite_i,
  input  logic              memtoreg_i,
  input  logic              dmem_ack_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              mem_stall_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  output logic [REG_AW-1:0] hold_rd_o,
  output logic              hold_regwrite_o,
  output logic              hold_memtoreg_o,
  output logic [DATA_W-1:0] hold_alu_o
);

  mem_state_e        state_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [REG_AW-1:0] rd_q;
  logic              regwrite_q;
  logic              memtoreg_q;
  logic [DATA_W-1:0] alu_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      alu_q      <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= BUSY;
            req_q      <= 1'b1;
            we_q       <= we_i;
            addr_q     <= alu_i[ADDR_W-1:0];
            wdata_q    <= wdata_i;
            rd_q       <= rd_i;
            regwrite_q <= regwrite_i;
            memtoreg_q <= memtoreg_i;
            alu_q      <= alu_i;
          end
        end
        BUSY: begin
          if (dmem_ack_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = (state_q == BUSY);
  assign done_o = busy_o & dmem_ack_i;

  // Hold upstream from the accept cycle until the ack cycle.
  assign mem_stall_o = busy_o ? ~dmem_ack_i : start_i;

  assign dmem_req_o      = req_q;
  assign dmem_we_o       = we_q;
  assign dmem_addr_o     = addr_q;
  assign dmem_wdata_o    = wdata_q;
  assign hold_rd_o       = rd_q;
  assign hold_regwrite_o = regwrite_q;
  assign hold_memtoreg_o = memtoreg_q;
  assign hold_alu_o      = alu_q;

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: runs loads/stores over a req/ack port, registers MEM/WB.
// Define MEM_ALIGN_CHECK_EN to trap misaligned accesses into memwb_exc.
module mem_wb_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              exmem_valid,
  input  logic [DATA_W-1:0] exmem_aluresult,
  input  logic [DATA_W-1:0] exmem_wdata,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              exmem_memread,
  input  logic              exmem_memwrite,
  input  logic              exmem_regwrite,
  input  logic              exmem_memtoreg,
  input  logic              flush,
  output logic              mem_stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              memwb_valid,
  output logic              memwb_regwrite,
  output logic [REG_AW-1:0] memwb_rd,
  output logic [DATA_W-1:0] memwb_wbdata,
  output logic              memwb_exc
);

  logic              accept;
  logic              is_mem;
  logic              mis;
  logic              start;
  logic              busy;
  logic              done;
  logic              idle_alu;
  logic              idle_exc;
  logic [REG_AW-1:0] hold_rd;
  logic              hold_regwrite;
  logic              hold_memtoreg;
  logic [DATA_W-1:0] hold_alu;
  memwb_t            memwb_d;
  memwb_t            memwb_q;

  assign accept = exmem_valid & ~flush;
  assign is_mem = exmem_memread | exmem_memwrite;

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = misaligned(exmem_aluresult[1:0]);
`else
  assign mis = 1'b0;
`endif

  assign start    = ~busy & accept & is_mem & ~mis;
  assign idle_alu = ~busy & accept & ~is_mem;
  assign idle_exc = ~busy & accept & is_mem & mis;

  dmem_req_ctrl #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .REG_AW (REG_AW)
  ) u_ctrl (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_i         (start),
    .alu_i           (exmem_aluresult),
    .wdata_i         (exmem_wdata),
    .we_i            (exmem_memwrite),
    .rd_i            (exmem_rd),
    .regwrite_i      (exmem_regwrite),
    .memtoreg_i      (exmem_memtoreg),
    .dmem_ack_i      (dmem_ack),
    .busy_o          (busy),
    .done_o          (done),
    .mem_stall_o     (mem_stall),
    .dmem_req_o      (dmem_req),
    .dmem_we_o       (dmem_we),
    .dmem_addr_o     (dmem_addr),
    .dmem_wdata_o    (dmem_wdata),
    .hold_rd_o       (hold_rd),
    .hold_regwrite_o (hold_regwrite),
    .hold_memtoreg_o (hold_memtoreg),
    .hold_alu_o      (hold_alu)
  );

  // Everything outside the three cases is a bubble with regwrite low.
  always_comb begin
    memwb_d = '0;
    unique case (1'b1)
      done: begin
        memwb_d.valid    = 1'b1;
        memwb_d.regwrite = hold_regwrite & ~dmem_we & (|hold_rd);
        memwb_d.rd       = hold_rd;
        memwb_d.wbdata   = hold_memtoreg ? dmem_rdata : hold_alu;
      end
      idle_alu: begin
        memwb_d.valid    = 1'b1;
        memwb_d.regwrite = exmem_regwrite & (|exmem_rd);
        memwb_d.rd       = exmem_rd;
        memwb_d.wbdata   = exmem_aluresult;
      end
      idle_exc: begin
        memwb_d.valid  = 1'b1;
        memwb_d.rd     = exmem_rd;
        memwb_d.wbdata = exmem_aluresult;
        memwb_d.exc    = 1'b1;
      end
      default: begin
        memwb_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      memwb_q <= '0;
    end else begin
      memwb_q <= memwb_d;
    end
  end

  assign memwb_valid    = memwb_q.valid;
  assign memwb_regwrite = memwb_q.regwrite & memwb_q.valid;
  assign memwb_rd       = memwb_q.rd;
  assign memwb_wbdata   = memwb_q.wbdata;
  assign memwb_exc      = memwb_q.exc;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: memory responder, transaction model and
// directed vectors with literal expectations.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst_n;
  logic        exmem_valid;
  logic [31:0] exmem_aluresult;
  logic [31:0] exmem_wdata;
  logic [4:0]  exmem_rd;
  logic        exmem_memread;
  logic        exmem_memwrite;
  logic        exmem_regwrite;
  logic        exmem_memtoreg;
  logic        flush;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        memwb_valid;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_wbdata;
  logic        memwb_exc;

  mem_wb_stage #(
    .DATA_W (32),
    .ADDR_W (32),
    .REG_AW (5)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .exmem_valid     (exmem_valid),
    .exmem_aluresult (exmem_aluresult),
    .exmem_wdata     (exmem_wdata),
    .exmem_rd        (exmem_rd),
    .exmem_memread   (exmem_memread),
    .exmem_memwrite  (exmem_memwrite),
    .exmem_regwrite  (exmem_regwrite),
    .exmem_memtoreg  (exmem_memtoreg),
    .flush           (flush),
    .mem_stall       (mem_stall),
    .dmem_req        (dmem_req),
    .dmem_we         (dmem_we),
    .dmem_addr       (dmem_addr),
    .dmem_wdata      (dmem_wdata),
    .dmem_ack        (dmem_ack),
    .dmem_rdata      (dmem_rdata),
    .memwb_valid     (memwb_valid),
    .memwb_regwrite  (memwb_regwrite),
    .memwb_rd        (memwb_rd),
    .memwb_wbdata    (memwb_wbdata),
    .memwb_exc       (memwb_exc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Word memory and req/ack responder
  logic [31:0] memv [64];
  int          ack_delay = 0;
  logic        force_ack = 1'b0;
  int          req_cnt = 0;
  int          req_seen = 0;
  logic [31:0] last_addr = '0;
  logic        last_we = 1'b0;
  logic [31:0] last_wdata = '0;

  initial begin
    dmem_ack   = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (dmem_req === 1'b1) begin
        req_cnt++;
        req_seen++;
        last_addr  = dmem_addr;
        last_we    = dmem_we;
        last_wdata = dmem_wdata;
        dmem_ack   = (req_cnt > ack_delay);
        if (dmem_ack && dmem_we) memv[dmem_addr[7:2]] = dmem_wdata;
        dmem_rdata = memv[dmem_addr[7:2]];
      end else begin
        req_cnt    = 0;
        dmem_ack   = force_ack;
        dmem_rdata = '0;
      end
    end
  end

  // Transaction model: one outstanding access at most
  logic        m_pend;
  logic [31:0] m_alu;
  logic [31:0] m_wdata;
  logic        m_we;
  logic [4:0]  m_rd;
  logic        m_rw;
  logic        m_m2r;
  logic        e_valid;
  logic        e_rw;
  logic        e_exc;
  logic [4:0]  e_rd;
  logic [31:0] e_wb;
  logic        s_exp;
  logic        acc;
  logic        ism;
  logic        ma;

  task automatic model_clear();
    m_pend  = 1'b0;
    e_valid = 1'b0;
    e_rw    = 1'b0;
    e_exc   = 1'b0;
    e_rd    = '0;
    e_wb    = '0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (!rst_n) model_clear();
      acc = exmem_valid & ~flush;
      ism = exmem_memread | exmem_memwrite;
`ifdef MEM_ALIGN_CHECK_EN
      ma = (exmem_aluresult % 4) != 0;
`else
      ma = 1'b0;
`endif
      s_exp = m_pend ? ~dmem_ack : (acc & ism & ~ma);
      chk("mem_stall", mem_stall, s_exp);
      chk("dmem_req", dmem_req, m_pend);
      chk("memwb_valid", memwb_valid, e_valid);
      chk("memwb_regwrite", memwb_regwrite, e_rw);
      chk("memwb_exc", memwb_exc, e_exc);
      if (e_valid && !e_exc) begin
        chk("memwb_rd", memwb_rd, e_rd);
        chk("memwb_wbdata", memwb_wbdata, e_wb);
      end
      if (m_pend) begin
        chk("dmem_addr", dmem_addr, m_alu);
        chk("dmem_we", dmem_we, m_we);
        chk("dmem_wdata", dmem_wdata, m_wdata);
      end
      if (rst_n) begin
        e_valid = 1'b0;
        e_rw    = 1'b0;
        e_exc   = 1'b0;
        e_rd    = '0;
        e_wb    = '0;
        if (m_pend) begin
          if (dmem_ack) begin
            m_pend  = 1'b0;
            e_valid = 1'b1;
            e_rd    = m_rd;
            e_rw    = m_rw && !m_we && m_rd != 0;
            e_wb    = m_m2r ? dmem_rdata : m_alu;
          end
        end else if (acc && ism && !ma) begin
          m_pend  = 1'b1;
          m_alu   = exmem_aluresult;
          m_wdata = exmem_wdata;
          m_we    = exmem_memwrite;
          m_rd    = exmem_rd;
          m_rw    = exmem_regwrite;
          m_m2r   = exmem_memtoreg;
        end else if (acc && ism) begin
          e_valid = 1'b1;
          e_exc   = 1'b1;
          e_rd    = exmem_rd;
        end else if (acc) begin
          e_valid = 1'b1;
          e_rd    = exmem_rd;
          e_rw    = exmem_regwrite && exmem_rd != 0;
          e_wb    = exmem_aluresult;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd,
                       input logic mr, input logic mw, input logic rw,
                       input logic m2r, input logic fl);
    exmem_valid     = v;
    exmem_aluresult = alu;
    exmem_wdata     = wd;
    exmem_rd        = rd;
    exmem_memread   = mr;
    exmem_memwrite  = mw;
    exmem_regwrite  = rw;
    exmem_memtoreg  = m2r;
    flush           = fl;
  endtask

  // Present one instruction and hold it while mem_stall is high.
  task automatic issue(input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] rd, input logic mr,
                       input logic mw, input logic rw, input logic m2r,
                       input logic fl, input logic fb, output int n);
    logic st;
    drive(1'b1, alu, wd, rd, mr, mw, rw, m2r, fl);
    n = 0;
    do begin
      @(negedge clk);
      st = mem_stall;
      @(posedge clk);
      #1;
      n++;
      if (fb && n == 1) flush = 1'b1;
    end while (st === 1'b1 && n < 64);
    if (n >= 64) chk("issue_timeout", 1, 0);
  endtask

  task automatic bubble(input int k);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  int n;
  int rs;

  initial begin
    for (int i = 0; i < 64; i++) memv[i] = 32'hA500_0000 | i;
    memv[16] = 32'hDEAD_BEEF;
    rst_n = 1'b1;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req", dmem_req, 0);
    chk("rst_valid", memwb_valid, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_wbdata", memwb_wbdata, 0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    issue(32'h0000_1234, 0, 5'd3, 0, 0, 1, 0, 0, 0, n);
    chk("alu_lat", n, 1);
    chk("alu_valid", memwb_valid, 1);
    chk("alu_wb", memwb_wbdata, 32'h1234);
    chk("alu_rd", memwb_rd, 3);
    chk("alu_rw", memwb_regwrite, 1);

    issue(32'h0000_0777, 0, 5'd0, 0, 0, 1, 0, 0, 0, n);
    chk("rd0_rw", memwb_regwrite, 0);
    chk("rd0_valid", memwb_valid, 1);

    ack_delay = 3;
    issue(32'h40, 0, 5'd7, 1, 0, 1, 1, 0, 0, n);
    chk("ld_stall_cycles", n - 1, 4);
    chk("ld_wb", memwb_wbdata, 32'hDEAD_BEEF);
    chk("ld_rw", memwb_regwrite, 1);
    chk("ld_addr", last_addr, 32'h40);
    chk("ld_we", last_we, 0);

    ack_delay = 0;
    issue(32'h80, 32'h55AA, 5'd0, 0, 1, 0, 0, 0, 0, n);
    chk("st_lat", n, 2);
    chk("st_valid", memwb_valid, 1);
    chk("st_rw", memwb_regwrite, 0);
    chk("st_we", last_we, 1);
    chk("st_wdata", last_wdata, 32'h55AA);
    chk("st_mem", memv[32], 32'h55AA);

    ack_delay = 1;
    issue(32'h80, 0, 5'd9, 1, 0, 1, 1, 0, 0, n);
    chk("ld2_lat", n, 3);
    chk("ld2_wb", memwb_wbdata, 32'h55AA);

    rs = req_seen;
    issue(32'h40, 0, 5'd4, 1, 0, 1, 1, 1, 0, n);
    chk("fl_lat", n, 1);
    chk("fl_valid", memwb_valid, 0);
    chk("fl_noreq", req_seen, rs);

    ack_delay = 2;
    issue(32'h44, 0, 5'd8, 1, 0, 1, 1, 0, 1, n);
    chk("flb_valid", memwb_valid, 1);
    chk("flb_wb", memwb_wbdata, 32'hA500_0011);
    bubble(1);

    force_ack = 1'b1;
    bubble(1);
    issue(32'h99, 0, 5'd9, 0, 0, 1, 0, 0, 0, n);
    chk("idle_ack_lat", n, 1);
    chk("idle_ack_wb", memwb_wbdata, 32'h99);
    force_ack = 1'b0;
    bubble(1);

    for (int i = 1; i < 6; i++) begin
      issue(32'h111 * i, 0, 5'(i + 10), 0, 0, i % 2, 0, 0, 0, n);
    end

    ack_delay = 10;
    drive(1'b1, 32'h48, 0, 5'd5, 1, 0, 1, 1, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("mrst_req", dmem_req, 0);
    chk("mrst_valid", memwb_valid, 0);
    chk("mrst_rw", memwb_regwrite, 0);
    chk("mrst_stall", mem_stall, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    ack_delay = 0;
    @(posedge clk);
    #1;
    issue(32'hCAFE, 0, 5'd2, 0, 0, 1, 0, 0, 0, n);
    chk("mrst_alu_lat", n, 1);
    chk("mrst_alu_wb", memwb_wbdata, 32'hCAFE);

    rs = req_seen;
    issue(32'h42, 0, 5'd6, 1, 0, 1, 1, 0, 0, n);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_lat", n, 1);
    chk("mis_exc", memwb_exc, 1);
    chk("mis_rw", memwb_regwrite, 0);
    chk("mis_valid", memwb_valid, 1);
    chk("mis_noreq", req_seen, rs);
`else
    chk("mis_lat", n, 2);
    chk("mis_addr", last_addr, 32'h42);
    chk("mis_exc", memwb_exc, 0);
    chk("mis_req", req_seen, rs + 1);
    chk("mis_wb", memwb_wbdata, 32'hDEAD_BEEF);
`endif

    bubble(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer end of the EX/MEM pipeline register: the memory stage of the 5-stage pipeline.
- Takes the EX/MEM bundle (ALU result, store data, destination register, control bits) and runs any load or store against the data memory using a req/ack handshake. It stalls upstream while the access is outstanding.
- Produces the registered MEM/WB bundle for writeback.

Parameters:
DATA_W, 32, datapath and memory data width
ADDR_W, 32, data memory address width (taken from the low bits of aluresult)
REG_AW, 5, register-file index width

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
exmem_valid  input  1  EX/MEM slot holds a real instruction
exmem_aluresult  input  DATA_W  ALU result; the memory address for loads and stores
exmem_wdata  input  DATA_W  store data (rt value)
exmem_rd  input  REG_AW  destination register
exmem_memread  input  1  instruction is a load
exmem_memwrite  input  1  instruction is a store
exmem_regwrite  input  1  instruction writes the register file
exmem_memtoreg  input  1  writeback selects load data, not the ALU result
flush  input  1  discard the EX/MEM instruction presented this cycle
mem_stall  output  1  hold EX/MEM and all earlier stages
dmem_req  output  1  data memory request
dmem_we  output  1  1 = write, 0 = read
dmem_addr  output  ADDR_W  access address
dmem_wdata  output  DATA_W  write data
dmem_ack  input  1  memory completed the request this cycle
dmem_rdata  input  DATA_W  read data, valid when dmem_ack
memwb_valid  output  1  MEM/WB slot valid
memwb_regwrite  output  1  registered regwrite, gated by valid
memwb_rd  output  REG_AW  registered destination
memwb_wbdata  output  DATA_W  writeback value: load data or ALU result
memwb_exc  output  1  misaligned-access exception (see Optional Feature)

Behaviour:
- Reset, asynchronous on rst_n low:
  - State is IDLE.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
  - All memwb_* outputs are 0.
  - mem_stall=0.
- The FSM has two states, IDLE and BUSY.
- An instruction is accepted when exmem_valid=1 and flush=0. An accepted instruction is a memory op when memread|memwrite.
- IDLE, non-memory op:
  - On the next edge: memwb_valid=1, memwb_wbdata=aluresult, rd and regwrite registered.
  - Latency is 1 cycle, with no stall.
- IDLE, memory op:
  - mem_stall=1 combinationally.
  - On the next edge: go to BUSY, register dmem_addr=aluresult[ADDR_W-1:0], dmem_wdata, dmem_we=memwrite, dmem_req=1.
  - Also register rd, regwrite and memtoreg into internal holding flops.
  - memwb_valid=0 (bubble).
- IDLE with no valid instruction or with flush=1: memwb_valid=0 on the next edge; regwrite is forced 0.
- BUSY:
  - dmem_req, dmem_we, dmem_addr and dmem_wdata are held stable until the cycle ack is sampled.
  - mem_stall=~dmem_ack.
  - memwb_valid=0 while waiting.
- BUSY with dmem_ack=1:
  - On the next edge: dmem_req=0, state=IDLE, memwb_valid=1.
  - memwb_wbdata = memtoreg ? dmem_rdata : held address value.
  - Stores write back with memwb_regwrite=0.
  - Minimum memory-op latency is 2 cycles (accept→req, req+ack→MEM/WB).
  - In the ack cycle mem_stall=0, so the next EX/MEM instruction is presented and is evaluated in IDLE in the following cycle. It is not accepted in the ack cycle.
- flush in BUSY is ignored: an in-flight access always completes and writes back.
- dmem_ack while in IDLE is ignored.
- memwb_regwrite = regwrite & valid always. memwb_regwrite is forced 0 when rd=0.
- Reset mid-access aborts immediately: dmem_req drops asynchronously and no writeback occurs.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined:
  - A memory op with aluresult[1:0]!=0 raises no dmem_req and takes no BUSY state.
  - On the next edge: memwb_valid=1, memwb_exc=1, memwb_regwrite=0. No stall.
- Undefined: no check is made, the address is passed unmodified, and memwb_exc is tied 0.

Decomposition:
- Shared package pipeline_pkg holds:
  - the DATA_W, REG_AW and ADDR_W defaults;
  - the FSM state typedef {IDLE, BUSY};
  - the MEM/WB bundle struct {valid, regwrite, rd, wbdata, exc}, shared with the existing EX/MEM stage and the writeback stage.
- One natural sub-module: dmem_req_ctrl, holding the FSM, the request hold registers and the stall generation. The top level keeps the MEM/WB output register and the writeback mux.

Test Plan:
- ALU op, exmem_valid=1, aluresult=0x0000_1234, rd=3, regwrite=1 → next cycle memwb_valid=1, wbdata=0x1234, rd=3, regwrite=1; mem_stall stays 0.
- Load of 0x40 with memory acking 3 cycles after req, rdata=0xDEAD_BEEF → mem_stall=1 for 4 cycles; dmem_addr=0x40 and dmem_we=0 held stable; then memwb_wbdata=0xDEADBEEF, regwrite=1.
- Store of 0x55AA to 0x80 with ack in the first req cycle → dmem_we=1, dmem_wdata=0x55AA; 2-cycle latency; memwb_valid=1 with memwb_regwrite=0.
- Flush with a load presented in IDLE → no dmem_req, memwb_valid=0. Flush asserted while BUSY → the access completes and memwb_valid=1.
- rst_n pulsed low while BUSY → dmem_req=0 and all memwb_*=0 immediately; after release, a new ALU op completes in 1 cycle.
- With MEM_ALIGN_CHECK_EN: load of 0x42 → no dmem_req, memwb_exc=1, regwrite=0. Without the macro: the same load issues dmem_addr=0x42.
